// File: rtl/rv_muldiv_pkg.sv
// rv_muldiv_pkg: shared encodings and helpers for the iterative RV M-extension unit.
package rv_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int FLAG_ZERO = 2;
  localparam int FLAG_DIVZ = 1;
  localparam int FLAG_OVF  = 0;

  function automatic logic is_signed_a(input logic [2:0] op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(input logic [2:0] op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: conditional two's-complement negate, used for operand magnitudes
// and for the final sign correction of products, quotients and remainders.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);
  assign o_val = i_neg ? -i_val : i_val;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: radix-2 iterative multiply/divide (RV M funct3 encoding) with
// valid/ready handshake, result hold under backpressure, flush and divide special cases.
module muldiv_unit
  import rv_muldiv_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [2:0]      flags
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e          r_state;
  logic [2:0]      r_op;
  logic            r_sa;
  logic            r_sb;
  logic            r_divz;
  logic            r_ovf;
  logic [XLEN-1:0] r_m;
  logic [2*XLEN-1:0] r_acc;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_result;
  logic [2:0]      r_flags;

  logic            w_sa;
  logic            w_sb;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic            w_accept;
  logic            w_divz;
  logic            w_ovf;
  logic            w_fast;
  logic [XLEN-1:0] w_spec;
  logic [2:0]      w_spec_flags;
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_rem_sh;
  logic [XLEN:0]   w_diff;
  logic [2*XLEN-1:0] w_mul_nxt;
  logic [2*XLEN-1:0] w_div_nxt;
  logic [2*XLEN-1:0] w_acc_nxt;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0] w_quo;
  logic [XLEN-1:0] w_rem;
  logic [XLEN-1:0] w_fin;
  logic [2:0]      w_fin_flags;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign flags     = r_flags;

  assign w_sa     = is_signed_a(op) & src_a[XLEN-1];
  assign w_sb     = is_signed_b(op) & src_b[XLEN-1];
  assign w_accept = in_valid & in_ready & ~flush;
  assign w_divz   = op[2] & ~|src_b;
  assign w_ovf    = (op == OP_DIV || op == OP_REM) & (src_a == MIN) & (&src_b);
  assign w_fast   = FAST_SPECIAL & (w_divz | w_ovf);
  assign w_spec   = w_divz ? (op[1] ? src_a : '1) : (op[1] ? '0 : MIN);

  muldiv_sign_fix #(.W(XLEN)) u_abs_a (.i_val(src_a), .i_neg(w_sa), .o_val(w_abs_a));
  muldiv_sign_fix #(.W(XLEN)) u_abs_b (.i_val(src_b), .i_neg(w_sb), .o_val(w_abs_b));

  // Multiply: shift-add, multiplier in the low half shifts out as the product shifts in.
  assign w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_m};
  assign w_mul_nxt = r_acc[0] ? {w_sum, r_acc[XLEN-1:1]} : {1'b0, r_acc[2*XLEN-1:1]};

  // Divide: restoring; high half is the partial remainder, low half dividend/quotient.
  assign w_rem_sh  = r_acc[2*XLEN-1:XLEN-1];
  assign w_diff    = w_rem_sh - {1'b0, r_m};
  assign w_div_nxt = w_diff[XLEN] ? {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                  : {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
  assign w_acc_nxt = r_op[2] ? w_div_nxt : w_mul_nxt;

  muldiv_sign_fix #(.W(2*XLEN)) u_fix_p (.i_val(w_acc_nxt), .i_neg(r_sa ^ r_sb), .o_val(w_prod));
  muldiv_sign_fix #(.W(XLEN)) u_fix_q (.i_val(w_acc_nxt[XLEN-1:0]), .i_neg(r_sa ^ r_sb), .o_val(w_quo));
  muldiv_sign_fix #(.W(XLEN)) u_fix_r (.i_val(w_acc_nxt[2*XLEN-1:XLEN]), .i_neg(r_sa), .o_val(w_rem));

  // Signed divide by zero would otherwise yield +1 for a negative dividend.
  assign w_fin = (r_divz & ~r_op[1]) ? '1 :
                 r_op[2] ? (r_op[1] ? w_rem : w_quo) :
                 (r_op == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  always_comb begin
    w_fin_flags = '0;
    w_fin_flags[FLAG_ZERO] = (w_fin == '0);
    w_fin_flags[FLAG_DIVZ] = r_divz;
    w_fin_flags[FLAG_OVF] = r_ovf;
    w_spec_flags = '0;
    w_spec_flags[FLAG_ZERO] = (w_spec == '0);
    w_spec_flags[FLAG_DIVZ] = w_divz;
    w_spec_flags[FLAG_OVF] = w_ovf;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_op     <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_divz   <= 1'b0;
      r_ovf    <= 1'b0;
      r_m      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_flags  <= '0;
    end else if (flush && r_state != IDLE) begin
      r_state <= IDLE;
    end else if (r_state == IDLE) begin
      if (w_accept) begin
        r_op   <= op;
        r_sa   <= w_sa;
        r_sb   <= w_sb;
        r_divz <= w_divz;
        r_ovf  <= w_ovf;
        r_m    <= op[2] ? w_abs_b : w_abs_a;
        r_acc  <= {{XLEN{1'b0}}, op[2] ? w_abs_a : w_abs_b};
        r_cnt  <= '0;
        if (w_fast) begin
          r_state  <= DONE;
          r_result <= w_spec;
          r_flags  <= w_spec_flags;
        end else begin
          r_state <= BUSY;
        end
      end
    end else if (r_state == BUSY) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == CW'(XLEN - 1)) begin
        r_state  <= DONE;
        r_result <= w_fin;
        r_flags  <= w_fin_flags;
      end
    end else if (out_ready) begin
      r_state <= IDLE;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors against a plain-arithmetic model, two instances
// covering FAST_SPECIAL=1 (u_fast) and FAST_SPECIAL=0 (u_slow).
module tb_muldiv_unit;
  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  typedef struct packed {
    logic [31:0] res;
    logic [2:0]  fl;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv_f = 1'b0, iv_s = 1'b0, flush = 1'b0, ordy = 1'b1;
  logic [2:0]  op = '0;
  logic [31:0] a = '0, b = '0;
  logic        ir_f, ir_s, ov_f, ov_s;
  logic [31:0] r_f, r_s;
  logic [2:0]  f_f, f_s;
  logic        sel = 1'b0;
  logic        ir, ov;
  logic [31:0] rs;
  logic [2:0]  fl;
  exp_t        q_f[$], q_s[$];
  int          n_vec = 0, n_err = 0;

  assign ir = sel ? ir_s : ir_f;
  assign ov = sel ? ov_s : ov_f;
  assign rs = sel ? r_s : r_f;
  assign fl = sel ? f_s : f_f;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .FAST_SPECIAL(1'b1)) u_fast (
    .clk(clk), .rst(rst), .in_valid(iv_f), .in_ready(ir_f), .op(op), .src_a(a), .src_b(b),
    .flush(flush), .out_valid(ov_f), .out_ready(ordy), .result(r_f), .flags(f_f));

  muldiv_unit #(.XLEN(32), .FAST_SPECIAL(1'b0)) u_slow (
    .clk(clk), .rst(rst), .in_valid(iv_s), .in_ready(ir_s), .op(op), .src_a(a), .src_b(b),
    .flush(flush), .out_valid(ov_s), .out_ready(ordy), .result(r_s), .flags(f_s));

  function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint ux = longint'({32'h0, x});
    longint uy = longint'({32'h0, y});
    logic [63:0] p = '0;
    logic [31:0] r = '0;
    logic dz = 1'b0, ovf = 1'b0;
    exp_t e;
    if (o == MUL) begin p = 64'(sx * sy); r = p[31:0]; end
    else if (o == MULH) begin p = 64'(sx * sy); r = p[63:32]; end
    else if (o == MULHSU) begin p = 64'(sx * uy); r = p[63:32]; end
    else if (o == MULHU) begin p = {32'h0, x} * {32'h0, y}; r = p[63:32]; end
    else if (y == 0) begin dz = 1'b1; r = (o == DIV || o == DIVU) ? 32'hFFFF_FFFF : x; end
    else if ((o == DIV || o == REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      ovf = 1'b1; r = (o == DIV) ? 32'h8000_0000 : 32'h0;
    end
    else if (o == DIV) r = 32'(sx / sy);
    else if (o == REM) r = 32'(sx % sy);
    else if (o == DIVU) r = 32'(ux / uy);
    else r = 32'(ux % uy);
    e.res = r;
    e.fl = {r == 32'h0, dz, ovf};
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ov_f) begin
      if (q_f.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL fast_unexpected_valid: got result %h with no pending op", r_f);
      end else begin
        chk("fast_model_result", r_f, q_f[0].res);
        chk("fast_model_flags", f_f, q_f[0].fl);
        if (ordy) void'(q_f.pop_front());
      end
    end
    if (!rst && ov_s) begin
      if (q_s.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL slow_unexpected_valid: got result %h with no pending op", r_s);
      end else begin
        chk("slow_model_result", r_s, q_s[0].res);
        chk("slow_model_flags", f_s, q_s[0].fl);
        if (ordy) void'(q_s.pop_front());
      end
    end
  end

  task automatic issue(input bit s, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    sel = s; op = o; a = x; b = y;
    if (s) iv_s = 1'b1; else iv_f = 1'b1;
    chk($sformatf("in_ready_idle op%0d", o), ir, 1);
    if (s) q_s.push_back(model(o, x, y)); else q_f.push_back(model(o, x, y));
    @(posedge clk);
    #1;
    iv_f = 1'b0; iv_s = 1'b0;
    op = 3'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_valid(output int lat, output bit busy_rdy);
    lat = 1; busy_rdy = 1'b0;
    while (!ov && lat < 100) begin
      if (ir) busy_rdy = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run(input bit s, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] er, input logic [2:0] ef, input int el);
    int lat;
    bit br;
    issue(s, o, x, y);
    wait_valid(lat, br);
    chk($sformatf("latency op%0d %h/%h", o, x, y), lat, el);
    chk($sformatf("in_ready_busy op%0d", o), br, 0);
    chk($sformatf("result op%0d %h,%h", o, x, y), rs, er);
    chk($sformatf("flags op%0d %h,%h", o, x, y), fl, ef);
    @(posedge clk);
    #1;
    chk("idle_after_take", {ov, ir}, 2'b01);
  endtask

  initial begin
    int lat;
    bit br, seen;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_result", r_f, 0);
    chk("reset_flags", f_f, 0);
    chk("reset_valid_ready", {ov_f, ir_f}, 2'b01);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run(0, MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 3'b000, 33);
    run(0, MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3'b000, 33);
    run(0, MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 3'b100, 33);
    run(0, MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 3'b000, 33);
    run(0, MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 3'b000, 33);
    run(0, MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 3'b000, 33);
    run(0, MUL,    32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 3'b100, 33);
    run(0, DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 3'b000, 33);
    run(0, REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 3'b000, 33);
    run(0, DIVU,   32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 3'b000, 33);
    run(0, REMU,   32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 3'b000, 33);
    run(0, REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 3'b000, 33);
    run(0, DIV,    32'h8000_0000, 32'h0000_0002, 32'hC000_0000, 3'b000, 33);
    run(0, DIVU,   32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 3'b000, 33);
    run(0, DIVU,   32'h0000_0064, 32'h0000_0000, 32'hFFFF_FFFF, 3'b010, 1);
    run(0, REMU,   32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 3'b010, 1);
    run(0, DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 3'b001, 1);
    run(0, REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 3'b101, 1);
    run(0, DIV,    32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, 3'b010, 1);
    run(0, REM,    32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 3'b010, 1);
    // backpressure: result parked in DONE
    ordy = 1'b0;
    issue(0, DIVU, 32'h0000_0064, 32'h0000_0007);
    wait_valid(lat, br);
    chk("bp_latency", lat, 33);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_hold%0d", i), {ov, ir, fl, rs}, {2'b10, 3'b000, 32'h0000_000E});
    end
    ordy = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release", {ov, ir}, 2'b01);
    // flush in BUSY cycle 10
    issue(0, MUL, 32'h0000_0005, 32'h0000_0006);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    void'(q_f.pop_front());
    chk("flush_idle", {ov, ir}, 2'b01);
    chk("flush_keeps_result", {fl, rs}, {3'b000, 32'h0000_000E});
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (ov) seen = 1'b1; end
    chk("flush_no_valid", seen, 0);
    run(0, MUL, 32'h0000_0003, 32'h0000_0004, 32'h0000_000C, 3'b000, 33);
    // flush beats a simultaneous accept
    sel = 1'b0; op = MUL; a = 32'h2; b = 32'h2; iv_f = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    iv_f = 1'b0; flush = 1'b0;
    chk("flush_accept_ready", {ov, ir}, 2'b01);
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (ov) seen = 1'b1; end
    chk("flush_accept_dropped", seen, 0);
    // asynchronous reset mid-BUSY
    issue(0, MUL, 32'h0000_0007, 32'h0000_0009);
    repeat (5) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {ov_f, ir_f, f_f, r_f}, {2'b01, 3'b000, 32'h0});
    q_f.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run(1, DIVU, 32'h0000_0064, 32'h0000_0000, 32'hFFFF_FFFF, 3'b010, 33);
    run(1, DIV,  32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, 3'b010, 33);
    run(1, REM,  32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 3'b010, 33);
    run(1, DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 3'b001, 33);
    run(1, REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 3'b101, 33);
    run(1, MULHU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 3'b000, 33);
    chk("queues_drained", {32'(q_f.size()), 32'(q_s.size())}, 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV M-extension multiply/divide unit that sits beside the single-cycle ALU in the execute stage.
- Accepts one operation through a valid/ready handshake and computes it in a radix-2 iteration of XLEN cycles.
- Holds the result and flags until the consumer takes them.
- Parametrised in XLEN. Adds multi-cycle behaviour, backpressure, flush and divide special cases that the combinational ALU does not have.

Parameters:
XLEN, 32, operand/result width; legal values 8..64, even.
FAST_SPECIAL, 1, when 1, divide-by-zero and signed overflow complete in 1 cycle; when 0, they run the full XLEN iterations with identical results.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operation request
in_ready  out  1  unit can accept (state IDLE)
op  in  3  RV funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
src_a  in  XLEN  rs1 operand
src_b  in  XLEN  rs2 operand
flush  in  1  synchronous kill of the in-flight operation
out_valid  out  1  result and flags valid
out_ready  in  1  consumer takes result
result  out  XLEN  result
flags  out  3  [2] zero result, [1] divide-by-zero, [0] signed-division overflow

Behaviour:
- Reset: state IDLE; in_ready=1; out_valid=0; result=0; flags=000; all internal registers 0. Reset asserted mid-operation aborts immediately, no result is produced.
- States:
  - IDLE to BUSY on in_valid&in_ready.
  - IDLE to DONE directly for a special case when FAST_SPECIAL=1.
  - BUSY to DONE when the iteration counter reaches XLEN-1.
  - DONE to IDLE on out_valid&out_ready.
- in_ready=1 only in IDLE. No new accept is possible in the same cycle a result is consumed.
- Capture at accept: op, operand magnitudes, sign of a (sa), sign of b (sb). Signedness per op:
  - a signed for MUL, MULH, MULHSU, DIV, REM.
  - b signed for MUL, MULH, DIV, REM.
  - MUL uses signed magnitudes; its low word is sign-independent.
- Multiply: 2*XLEN accumulator, one shift-add per BUSY cycle. At the DONE transition, negate the product if sa^sb. MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide: restoring, one quotient bit per BUSY cycle on magnitudes. Quotient sign is sa^sb; remainder sign is sa. Unsigned ops ignore signs.
- Latency:
  - Normal ops: accept in cycle 0, out_valid first high in cycle XLEN+1 (33 for XLEN=32).
  - Special cases with FAST_SPECIAL=1: out_valid high in cycle 1.
- Divide by zero (b==0):
  - DIV/DIVU: result all-ones.
  - REM/REMU: result src_a.
  - flags[1]=1.
- Signed overflow (DIV/REM, a==MIN, b==all-ones):
  - DIV: result MIN.
  - REM: result 0.
  - flags[0]=1.
- flags[2] = (result==0), computed on the final result.
- Multiply ops never set flags[1:0].
- Backpressure: in DONE with out_ready=0, result, flags and out_valid hold stable indefinitely.
- Flush:
  - In BUSY or DONE: next edge goes to IDLE with out_valid=0, and result/flags keep their last values.
  - In IDLE: no effect.
  - flush together with in_valid&in_ready: flush wins and the operation is not accepted. in_ready stays 1 that cycle; the bench must treat the request as dropped.
- Operands on src_a/src_b/op are don't-care outside the accept cycle.

Decomposition:
- Package rv_muldiv_pkg holds:
  - op enum (funct3 encodings above).
  - state enum {IDLE, BUSY, DONE}.
  - flag index constants FLAG_ZERO=2, FLAG_DIVZ=1, FLAG_OVF=0.
  - helper function is_signed_a/is_signed_b(op).
- One sub-module, muldiv_sign_fix: combinational conditional two's-complement negate of XLEN or 2*XLEN bits. It is used for operand magnitudes and for final correction.
- Counter, FSM and datapath stay in muldiv_unit.

Test Plan:
1. XLEN=32, MUL a=00000007, b=FFFFFFFD -> result FFFFFFEB, flags 000. out_valid first high 33 cycles after accept; in_ready low throughout.
2. MULHU a=b=FFFFFFFF -> FFFFFFFE, flags 000. MULH same operands -> 00000000, flags 100. MULHSU a=FFFFFFFF, b=00000002 -> FFFFFFFF.
3. DIV a=FFFFFFF9 (-7), b=00000002 -> FFFFFFFD. REM same operands -> FFFFFFFF. DIVU a=00000064, b=00000007 -> 0000000E. REMU same operands -> 00000002.
4. DIVU a=00000064, b=0 -> FFFFFFFF, flags 010, out_valid in cycle 1. REMU same operands -> 00000064, flags 010. DIV a=80000000, b=FFFFFFFF -> 80000000, flags 001. REM same operands -> 00000000, flags 101.
5. Backpressure and flush:
   - Hold out_ready=0 for 5 cycles in DONE -> result/flags/out_valid stable.
   - Assert flush in BUSY cycle 10 -> IDLE next edge, out_valid never rises, and a following MUL 3*4 returns 0000000C.
6. Reset and FAST_SPECIAL=0:
   - Assert rst asynchronously mid-BUSY -> out_valid=0, result=0, in_ready=1 without a clock edge.
   - With FAST_SPECIAL=0, DIVU by 0 takes 33 cycles and returns FFFFFFFF.
